sq_instr_injector: RTL and testbench
====================================

// Module: sq_instr_injector
// PURPOSE
//  Write-side counterpart of the SQ register: queues host-supplied 16-bit instruction words
//  and writes them onto the write lines (WL_n) with a WT_n strobe, timed to the NISQ/T10 window,
//  so the SQ register latches them at T12. Used by the simulation bench and monitor to force
//  instruction sequences without core memory; bus is released (all-ones) whenever idle.
// PARAMETERS
//  DEPTH      4  instruction FIFO entries (power of 2, >=2)
//  WT_CYCLES  2  CLOCK cycles WT_n held low per injection (>=1)
//  CNT_W      8  width of INJ_COUNT
// PORTS
//  CLOCK       in   1      system clock; all state on rising edge
//  SIM_RST     in   1      synchronous, active-low reset
//  INJ_DATA    in   16     instruction word, bit15 = WL16
//  INJ_VALID   in   1      host offers INJ_DATA
//  INJ_READY   out  1      FIFO can accept; push = INJ_VALID & INJ_READY
//  NISQ        in   1      next-instruction request, active high, one-cycle pulse
//  T10_n       in   1      time-pulse 10, active low
//  GOJAM       in   1      restart; aborts any injection in progress
//  WL_n        out  16     write lines, active low (driven ~word while DRIVE, else 16'hFFFF)
//  WT_n        out  1      write strobe, active low
//  INJ_ACTIVE  out  1      high in ARMED or DRIVE
//  EXT_PEND    out  1      last injected word was EXTEND (16'o000006)
//  UNDERRUN    out  1      sticky: armed window reached T10 with FIFO empty
//  OVERLAP     out  1      sticky: NISQ seen while ARMED or DRIVE
//  INJ_COUNT   out  CNT_W  words injected, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (SIM_RST=0 at edge): state IDLE, FIFO empty, WL_n=16'hFFFF, WT_n=1, INJ_READY=1,
//   INJ_ACTIVE=0, EXT_PEND=0, UNDERRUN=0, OVERLAP=0, INJ_COUNT=0. Reset mid-DRIVE releases bus next edge.
//  FIFO: INJ_READY = !full (no same-cycle bypass); push while full impossible; order preserved.
//  FSM:
//   IDLE  -> ARMED on NISQ=1.
//   ARMED -> on T10_n=0: FIFO non-empty -> DRIVE, load head word, timer=WT_CYCLES;
//            FIFO empty -> set UNDERRUN, -> IDLE, bus untouched.
//   DRIVE -> WL_n=~word, WT_n=0 registered (first low cycle = edge after T10_n sampled low);
//            timer decrements; after WT_CYCLES cycles: pop FIFO, INJ_COUNT+=1,
//            EXT_PEND=(word==16'o000006), WL_n=FFFF, WT_n=1, -> IDLE (same edge).
//  WL_n and WT_n change on the same edge; WL_n never changes while WT_n=0.
//  GOJAM=1 (any state): -> IDLE, bus released next edge, FIFO kept, no pop, no count, EXT_PEND=0.
//   GOJAM has priority over NISQ and T10_n in the same cycle.
//  NISQ in ARMED/DRIVE: set OVERLAP, otherwise ignored (no re-arm).
//  Push and pop in same cycle: both occur; occupancy unchanged.
//  T10_n low held for several cycles: only the first sampled cycle in ARMED acts.
//  UNDERRUN/OVERLAP clear only on reset.
// STRUCTURE
//  Shared package agc_sim_pkg: EXTEND_WORD=16'o000006, WL_IDLE=16'hFFFF,
//   typedef inj_state_t {IDLE, ARMED, DRIVE}.
//  One sub-module: sq_inj_fifo (DEPTH x 16, push/pop/full/empty, registered head).
//  FSM, timer, counters and flags in the top.
// TESTING
//  1 Push 16'o030001; NISQ; T10_n low -> WT_n low 2 cycles, WL_n=~16'o030001, INJ_COUNT=1, FIFO empty.
//  2 Push 4 words (INJ_READY drops after 4th), 4 NISQ/T10 windows -> words emitted in order, count=4.
//  3 NISQ + T10 with empty FIFO -> UNDERRUN=1, WT_n stays 1, WL_n=FFFF, state IDLE.
//  4 Inject 16'o000006 then 16'o050000 -> EXT_PEND 1 after first, 0 after second.
//  5 GOJAM in 1st DRIVE cycle -> WT_n=1, WL_n=FFFF next edge; word remains at head, count unchanged.
//  6 NISQ during DRIVE -> OVERLAP=1, injection completes normally; SIM_RST=0 mid-DRIVE -> all reset values.

Source files
------------

// File: rtl/agc_sim_pkg.sv
// Shared simulation-support definitions for the AGC instruction injector.
package agc_sim_pkg;

  localparam logic [15:0] EXTEND_WORD = 16'o000006;
  localparam logic [15:0] WL_IDLE     = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DRIVE
  } inj_state_t;

endpackage : agc_sim_pkg

// File: rtl/sq_inj_fifo.sv
// Instruction word FIFO for the SQ injector: DEPTH x WIDTH, head word read from the register array.
module sq_inj_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Push is refused while full even if a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sq_inj_fifo

// File: rtl/sq_instr_injector.sv
// Queues host instruction words and drives them onto WL_n with a WT_n strobe in the NISQ/T10 window.
module sq_instr_injector
  import agc_sim_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WT_CYCLES = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             CLOCK,
  input  logic             SIM_RST,
  input  logic [15:0]      INJ_DATA,
  input  logic             INJ_VALID,
  output logic             INJ_READY,
  input  logic             NISQ,
  input  logic             T10_n,
  input  logic             GOJAM,
  output logic [15:0]      WL_n,
  output logic             WT_n,
  output logic             INJ_ACTIVE,
  output logic             EXT_PEND,
  output logic             UNDERRUN,
  output logic             OVERLAP,
  output logic [CNT_W-1:0] INJ_COUNT
);

  localparam int unsigned TW = $clog2(WT_CYCLES + 1);

  inj_state_t       r_state;
  inj_state_t       w_state_nxt;
  logic [TW-1:0]    r_timer;
  logic [15:0]      r_word;
  logic [CNT_W-1:0] r_count;
  logic             r_ext_pend;
  logic             r_underrun;
  logic             r_overlap;

  logic             w_full;
  logic             w_empty;
  logic [15:0]      w_head;
  logic             w_push;
  logic             w_start;
  logic             w_done;
  logic             w_under_set;
  logic             w_over_set;

  assign w_push = INJ_VALID && !w_full;

  sq_inj_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .i_clk   (CLOCK),
    .i_rst_n (SIM_RST),
    .i_push  (w_push),
    .i_pop   (w_done),
    .i_data  (INJ_DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge CLOCK) begin
    if (!SIM_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // GOJAM overrides every transition and suppresses flag/pop side effects of NISQ and T10_n.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_under_set = 1'b0;
    w_over_set  = 1'b0;
    if (GOJAM) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (NISQ) begin
            w_state_nxt = ARMED;
          end
        end
        ARMED: begin
          w_over_set = NISQ;
          if (!T10_n) begin
            if (!w_empty) begin
              w_state_nxt = DRIVE;
              w_start     = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_under_set = 1'b1;
            end
          end
        end
        DRIVE: begin
          w_over_set = NISQ;
          if (r_timer == TW'(1)) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Bus outputs follow the state register directly, so WL_n and WT_n always switch on the same edge.
  always_comb begin
    WL_n       = WL_IDLE;
    WT_n       = 1'b1;
    INJ_ACTIVE = (r_state != IDLE);
    if (r_state == DRIVE) begin
      WL_n = ~r_word;
      WT_n = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!SIM_RST) begin
      r_timer    <= '0;
      r_word     <= '0;
      r_count    <= '0;
      r_ext_pend <= 1'b0;
      r_underrun <= 1'b0;
      r_overlap  <= 1'b0;
    end else begin
      if (w_start) begin
        r_timer <= TW'(WT_CYCLES);
        r_word  <= w_head;
      end else if (r_state == DRIVE && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
      if (w_done) begin
        r_count <= r_count + 1'b1;
      end
      if (GOJAM) begin
        r_ext_pend <= 1'b0;
      end else if (w_done) begin
        r_ext_pend <= (r_word == EXTEND_WORD);
      end
      if (w_under_set) begin
        r_underrun <= 1'b1;
      end
      if (w_over_set) begin
        r_overlap <= 1'b1;
      end
    end
  end

  assign INJ_READY = !w_full;
  assign EXT_PEND  = r_ext_pend;
  assign UNDERRUN  = r_underrun;
  assign OVERLAP   = r_overlap;
  assign INJ_COUNT = r_count;

endmodule : sq_instr_injector

// File: tb/tb_sq_instr_injector.sv
// Self-checking bench for sq_instr_injector against a queue-based reference model.
module tb_sq_instr_injector;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned WT_CYCLES = 2;
  localparam int unsigned CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      inj_data = '0;
  logic             inj_valid = 1'b0;
  logic             inj_ready;
  logic             nisq = 1'b0;
  logic             t10_n = 1'b1;
  logic             gojam = 1'b0;
  logic [15:0]      wl_n;
  logic             wt_n;
  logic             inj_active;
  logic             ext_pend;
  logic             underrun;
  logic             overlap;
  logic [CNT_W-1:0] inj_count;

  int errors = 0;
  int checks = 0;

  logic [15:0]      q[$];
  logic [CNT_W-1:0] m_count = '0;
  logic             m_ext = 1'b0;
  logic             m_under = 1'b0;
  logic             m_over = 1'b0;

  sq_instr_injector #(
    .DEPTH     (DEPTH),
    .WT_CYCLES (WT_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .CLOCK      (clk),
    .SIM_RST    (rst_n),
    .INJ_DATA   (inj_data),
    .INJ_VALID  (inj_valid),
    .INJ_READY  (inj_ready),
    .NISQ       (nisq),
    .T10_n      (t10_n),
    .GOJAM      (gojam),
    .WL_n       (wl_n),
    .WT_n       (wt_n),
    .INJ_ACTIVE (inj_active),
    .EXT_PEND   (ext_pend),
    .UNDERRUN   (underrun),
    .OVERLAP    (overlap),
    .INJ_COUNT  (inj_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_count = '0;
    m_ext   = 1'b0;
    m_under = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] d);
    logic exp_rdy;
    exp_rdy = (q.size() < DEPTH);
    checks++;
    if (inj_ready !== exp_rdy) begin
      errors++;
      $display("FAIL push_ready: INJ_READY=%b expected %b", inj_ready, exp_rdy);
    end
    inj_data  = d;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    if (exp_rdy) q.push_back(d);
  endtask

  // One NISQ/T10 window; the model says what the bus must show from the queue front.
  task automatic do_inject(input bit hold_t10, input bit nisq_mid, input bit push_done,
                           input logic [15:0] pw);
    logic [15:0] w;
    bit          rdy;
    rdy  = 1'b0;
    nisq = 1'b1;
    tick();
    nisq = 1'b0;
    checks++;
    if (inj_active !== 1'b1 || wt_n !== 1'b1) begin
      errors++;
      $display("FAIL armed: active=%b wt_n=%b expected 1 1", inj_active, wt_n);
    end
    t10_n = 1'b0;
    tick();
    if (q.size() == 0) begin
      m_under = 1'b1;
      checks++;
      if (underrun !== 1'b1 || wt_n !== 1'b1 || wl_n !== 16'hFFFF || inj_active !== 1'b0) begin
        errors++;
        $display("FAIL underrun: under=%b wt_n=%b wl_n=%h active=%b expected 1 1 ffff 0",
                 underrun, wt_n, wl_n, inj_active);
      end
      t10_n = 1'b1;
      return;
    end
    w = q[0];
    for (int c = 0; c < WT_CYCLES; c++) begin
      checks++;
      if (wt_n !== 1'b0 || wl_n !== ~w) begin
        errors++;
        $display("FAIL drive_c%0d: wt_n=%b wl_n=%h expected 0 %h", c, wt_n, wl_n, ~w);
      end
      if (!hold_t10) t10_n = 1'b1;
      if (nisq_mid && c == 0) begin
        nisq   = 1'b1;
        m_over = 1'b1;
      end
      if (push_done && c == WT_CYCLES - 1) begin
        rdy       = (q.size() < DEPTH);
        inj_data  = pw;
        inj_valid = 1'b1;
      end
      tick();
      nisq      = 1'b0;
      inj_valid = 1'b0;
    end
    void'(q.pop_front());
    if (push_done && rdy) q.push_back(pw);
    m_count = m_count + 1'b1;
    m_ext   = (w == 16'o000006);
    checks++;
    if (wt_n !== 1'b1 || wl_n !== 16'hFFFF || inj_active !== 1'b0) begin
      errors++;
      $display("FAIL release: wt_n=%b wl_n=%h active=%b expected 1 ffff 0", wt_n, wl_n, inj_active);
    end
    checks++;
    if (inj_count !== m_count || ext_pend !== m_ext) begin
      errors++;
      $display("FAIL done_state: count=%0d ext=%b expected %0d %b", inj_count, ext_pend, m_count, m_ext);
    end
    checks++;
    if (overlap !== m_over || underrun !== m_under || inj_ready !== (q.size() < DEPTH)) begin
      errors++;
      $display("FAIL done_flags: over=%b under=%b ready=%b expected %b %b %b",
               overlap, underrun, inj_ready, m_over, m_under, (q.size() < DEPTH));
    end
    if (hold_t10) tick();
    t10_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (wl_n !== 16'hFFFF || wt_n !== 1'b1 || inj_ready !== 1'b1 || inj_active !== 1'b0 ||
        ext_pend !== 1'b0 || underrun !== 1'b0 || overlap !== 1'b0 || inj_count !== '0) begin
      errors++;
      $display("FAIL %s: wl=%h wt=%b rdy=%b act=%b ext=%b und=%b ovl=%b cnt=%0d expected ffff 1 1 0 0 0 0 0",
               tag, wl_n, wt_n, inj_ready, inj_active, ext_pend, underrun, overlap, inj_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_single();
    do_push(16'o030001);
    do_inject(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (inj_count !== 8'd1 || inj_ready !== 1'b1) begin
      errors++;
      $display("FAIL single: count=%0d ready=%b expected 1 1", inj_count, inj_ready);
    end
  endtask

  task automatic test_fill_order();
    logic [CNT_W-1:0] base;
    base = m_count;
    for (int i = 0; i < DEPTH; i++) do_push(16'(16'o010000 + i * 16'o111));
    checks++;
    if (inj_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: INJ_READY=%b expected 0", inj_ready);
    end
    do_push(16'o077777);
    for (int i = 0; i < DEPTH; i++) do_inject(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (inj_count !== base + CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL fill_count: count=%0d expected %0d", inj_count, base + CNT_W'(DEPTH));
    end
  endtask

  task automatic test_underrun();
    do_inject(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (underrun !== 1'b1 || inj_active !== 1'b0 || wl_n !== 16'hFFFF) begin
      errors++;
      $display("FAIL underrun_sticky: under=%b act=%b wl=%h expected 1 0 ffff", underrun, inj_active, wl_n);
    end
  endtask

  task automatic test_extend();
    do_push(16'o000006);
    do_push(16'o050000);
    do_inject(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (ext_pend !== 1'b1) begin
      errors++;
      $display("FAIL ext_set: EXT_PEND=%b expected 1", ext_pend);
    end
    do_inject(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (ext_pend !== 1'b0) begin
      errors++;
      $display("FAIL ext_clear: EXT_PEND=%b expected 0", ext_pend);
    end
  endtask

  task automatic enter_drive();
    nisq = 1'b1;
    tick();
    nisq  = 1'b0;
    t10_n = 1'b0;
    tick();
    t10_n = 1'b1;
  endtask

  task automatic test_gojam();
    if (q.size() == 0) do_push(16'o000006);
    enter_drive();
    gojam = 1'b1;
    nisq  = 1'b1;
    tick();
    gojam = 1'b0;
    nisq  = 1'b0;
    m_ext = 1'b0;
    checks++;
    if (wt_n !== 1'b1 || wl_n !== 16'hFFFF || inj_active !== 1'b0) begin
      errors++;
      $display("FAIL gojam_bus: wt=%b wl=%h act=%b expected 1 ffff 0", wt_n, wl_n, inj_active);
    end
    checks++;
    if (inj_count !== m_count || ext_pend !== m_ext || overlap !== m_over) begin
      errors++;
      $display("FAIL gojam_state: cnt=%0d ext=%b ovl=%b expected %0d %b %b",
               inj_count, ext_pend, overlap, m_count, m_ext, m_over);
    end
    do_inject(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_overlap_reset();
    do_push(16'o012345);
    do_inject(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (overlap !== 1'b1) begin
      errors++;
      $display("FAIL overlap: OVERLAP=%b expected 1", overlap);
    end
    do_push(16'o054321);
    enter_drive();
    rst_n = 1'b0;
    tick();
    check_reset_values("reset_mid_drive");
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      logic [15:0] w;
      sel = $urandom_range(0, 4);
      w   = ($urandom_range(0, 3) == 0) ? 16'o000006 : 16'($urandom);
      case (sel)
        0, 1: do_push(w);
        2:    do_inject($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, w);
        3:    do_inject(1'b0, $urandom_range(0, 3) == 0, 1'b1, w);
        default: begin
          if (q.size() != 0) test_gojam();
          else do_inject(1'b0, 1'b0, 1'b0, '0);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_underrun();
    test_extend();
    test_gojam();
    test_overlap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sq_instr_injector
